// File: rtl/btn_debounce_sel_pkg.sv
// btn_debounce_sel_pkg: debounce FSM state encoding, display-select codes and select stepping
package btn_debounce_sel_pkg;
  typedef enum logic [1:0] {
    LOW       = 2'b00,
    WAIT_HIGH = 2'b01,
    HIGH      = 2'b10,
    WAIT_LOW  = 2'b11
  } db_state_t;
  typedef enum logic [1:0] {
    SEL_A    = 2'b00,
    SEL_B    = 2'b01,
    SEL_SUM  = 2'b10,
    SEL_SUM2 = 2'b11
  } sel_t;
  // NEXT alone steps up, PREV alone steps down, both together cancel
  function automatic logic [1:0] sel_step(input logic [1:0] sel, input logic [1:0] press);
    return press == 2'b01 ? sel + 2'd1 : press == 2'b10 ? sel - 2'd1 : sel;
  endfunction
endpackage

// File: rtl/btn_debounce_sel_debounce_1.sv
// btn_debounce_1: synchroniser, stability counter and debounce FSM for one push-button
module btn_debounce_1
  import btn_debounce_sel_pkg::*;
#(
  parameter int DB_CYCLES   = 1000000,
  parameter int CNT_W       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  db_state_t              state_q;
  logic                   press_q;
  logic                   s;
  logic                   expired;
  assign s       = sync_q[SYNC_STAGES-1];
  assign expired = cnt_q == CNT_LAST;
  assign level   = state_q == HIGH || state_q == WAIT_LOW;
  assign press   = press_q;
  // counter stops at CNT_LAST because expiry always leaves the WAIT state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= LOW;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      press_q <= state_q == WAIT_HIGH && s && expired;
      case (state_q)
        LOW:       if (s) begin state_q <= WAIT_HIGH; cnt_q <= '0; end
        WAIT_HIGH: if (!s) state_q <= LOW; else if (expired) state_q <= HIGH; else cnt_q <= cnt_q + 1'b1;
        HIGH:      if (!s) begin state_q <= WAIT_LOW; cnt_q <= '0; end
        default:   if (s) state_q <= HIGH; else if (expired) state_q <= LOW; else cnt_q <= cnt_q + 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/btn_debounce_sel.sv
// btn_debounce_sel: debounces NEXT/PREV buttons and keeps the display-select code
module btn_debounce_sel
  import btn_debounce_sel_pkg::*;
#(
  parameter int DB_CYCLES   = 1000000,
  parameter int CNT_W       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_raw,
  output logic [1:0] btn_level,
  output logic [1:0] btn_press,
  output logic [1:0] btn_sel
);
  logic [1:0] sel_q;
  for (genvar i = 0; i < 2; i++) begin : g_btn
    btn_debounce_1 #(
      .DB_CYCLES  (DB_CYCLES),
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sel_q <= SEL_A;
    else sel_q <= sel_step(sel_q, btn_press);
  end
  assign btn_sel = sel_q;
endmodule

// File: tb/tb_btn_debounce_sel.sv
// tb_btn_debounce_sel: directed plan plus random button traffic against a run-length reference model
module tb_btn_debounce_sel;
  localparam int DB = 4, CW = 3, SY = 2;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_level, btn_press, btn_sel;
  btn_debounce_sel #(.DB_CYCLES(DB), .CNT_W(CW), .SYNC_STAGES(SY)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_sel(btn_sel)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0;
  logic [1:0] hist[$];
  int run[2];
  int pcnt[2];
  logic [1:0] m_lvl, m_prs, m_sel;
  int cyc, lat, sel_cyc;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    hist.delete();
    repeat (SY) hist.push_back(2'b00);
    run   = '{0, 0};
    m_lvl = 2'b00;
    m_prs = 2'b00;
    m_sel = 2'b00;
  endtask
  // A level flips once the synchronised input has disagreed with it for DB+1 consecutive samples
  task automatic model_edge(input logic [1:0] r);
    logic [1:0] s;
    if (m_prs == 2'b01) m_sel = m_sel + 2'd1;
    else if (m_prs == 2'b10) m_sel = m_sel - 2'd1;
    s = hist.pop_front();
    hist.push_back(r);
    m_prs = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (s[i] != m_lvl[i]) begin
        run[i]++;
        if (run[i] == DB + 1) begin
          m_lvl[i] = s[i];
          m_prs[i] = s[i];
          run[i]   = 0;
        end
      end else run[i] = 0;
    end
  endtask
  task automatic step(input logic [1:0] r);
    btn_raw = r;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    check("level", btn_level, m_lvl);
    check("press", btn_press, m_prs);
    check("sel", btn_sel, m_sel);
    pcnt[0] += btn_press[0];
    pcnt[1] += btn_press[1];
  endtask
  task automatic hold(input logic [1:0] r, input int n);
    repeat (n) step(r);
  endtask
  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_level", btn_level, 2'b00);
    check("rst_press", btn_press, 2'b00);
    check("rst_sel", btn_sel, 2'b00);
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic press_release(input logic [1:0] r);
    hold(r, 20);
    hold(2'b00, 20);
  endtask
  initial begin
    model_reset();
    pcnt = '{0, 0};
    repeat (5) @(negedge clk);
    check("por_level", btn_level, 2'b00);
    check("por_sel", btn_sel, 2'b00);
    reset = 1'b1;
    hold(2'b00, 20);
    lat = -1;
    sel_cyc = -1;
    for (cyc = 0; cyc < 20; cyc++) begin
      step(2'b01);
      if (btn_press[0] && lat < 0) lat = cyc;
      if (btn_sel == 2'b01 && sel_cyc < 0) sel_cyc = cyc;
    end
    check("lat_window", lat >= SY + DB && lat <= SY + DB + 2, 1);
    check("sel_after_press", sel_cyc, lat + 1);
    check("level0_held", btn_level[0], 1'b1);
    hold(2'b00, 20);
    check("one_pulse", pcnt[0], 1);
    press_release(2'b01);
    check("sel_2", btn_sel, 2'b10);
    press_release(2'b01);
    check("sel_3", btn_sel, 2'b11);
    press_release(2'b01);
    check("sel_wrap_up", btn_sel, 2'b00);
    pcnt = '{0, 0};
    hold(2'b10, 20);
    check("sel_wrap_down", btn_sel, 2'b11);
    lat = -1;
    for (cyc = 0; cyc < 20; cyc++) begin
      step(2'b00);
      if (!btn_level[1] && lat < 0) lat = cyc;
    end
    check("release_lat", lat >= SY + DB && lat <= SY + DB + 2, 1);
    check("no_release_pulse", pcnt[1], 1);
    pcnt = '{0, 0};
    hold(2'b01, 2); hold(2'b00, 1); hold(2'b01, 2); hold(2'b00, 20);
    check("glitch_press", pcnt[0], 0);
    check("glitch_sel", btn_sel, 2'b11);
    pcnt = '{0, 0};
    lat = -1;
    for (cyc = 0; cyc < 20; cyc++) begin
      step(2'b11);
      if (btn_press == 2'b11 && lat < 0) lat = cyc;
    end
    hold(2'b00, 20);
    check("both_same_cycle", lat >= 0, 1);
    check("both_sel", btn_sel, 2'b11);
    press_release(2'b01);
    press_release(2'b01);
    press_release(2'b01);
    check("pre_reset_sel", btn_sel, 2'b10);
    pcnt = '{0, 0};
    hold(2'b01, 4);
    do_reset(3);
    hold(2'b01, 20);
    check("held_thru_reset", pcnt[0], 1);
    check("post_reset_sel", btn_sel, 2'b01);
    hold(2'b00, 20);
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
      hold(2'($urandom_range(0, 3)), $urandom_range(1, 12));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/btn_debounce_sel.md
Name: btn_debounce_sel

Overview:
Input-conditioning stage placed directly upstream of the display multiplexor in the sign-magnitude adder test top. Synchronises and debounces the two raw board push-buttons, then emits one-cycle press pulses. Maintains a registered 2-bit display-select code that drives the multiplexor select input: 00 = operand a, 01 = operand b, 10/11 = sum. The select code replaces the raw button wiring.

Parameters:
DB_CYCLES, 1000000, number of consecutive stable clk cycles required to accept a level change (20 ms at 50 MHz). Must be >= 2.
CNT_W, 20, counter width. Must satisfy 2^CNT_W > DB_CYCLES.
SYNC_STAGES, 2, synchroniser flip-flop depth per button. Must be >= 2.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
btn_raw  in  2  raw asynchronous push-buttons, active-high; [0] = NEXT, [1] = PREV
btn_level  out  2  debounced, registered button levels
btn_press  out  2  one-cycle pulse on each accepted rising edge of btn_level
btn_sel  out  2  registered display-select code for the downstream multiplexor

Behaviour:
- Reset (reset=0, asynchronous assert): synchroniser FFs, counters, FSMs and all outputs go to 0. btn_sel=00, btn_level=00, btn_press=00. Reset release must be applied synchronously to clk by the integrating top; no internal release synchroniser.
- Synchroniser: each btn_raw bit passes through SYNC_STAGES FFs. The debounce FSM sees only the last stage (s).
- Debounce FSM, one instance per button:
  - States: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
  - LOW: if s=1, go to WAIT_HIGH and clear cnt.
  - WAIT_HIGH: if s=0, return to LOW. Otherwise cnt++. When cnt reaches DB_CYCLES-1 with s=1, go to HIGH.
  - HIGH: if s=0, go to WAIT_LOW and clear cnt.
  - WAIT_LOW: mirror of WAIT_HIGH, returning to HIGH on glitch or entering LOW on expiry.
  - btn_level=1 in HIGH and WAIT_LOW, 0 otherwise.
  - Counter saturates; it never wraps.
- btn_press[i]: registered, high exactly one cycle, in the cycle after the WAIT_HIGH->HIGH transition, i.e. coincident with the first cycle btn_level[i]=1. Release never pulses.
- Latency: a clean raw rising edge gives btn_level/btn_press high SYNC_STAGES+DB_CYCLES+1 cycles after the first clk sampling btn_raw=1 (±1 cycle; the bench checks a window of exactly that width).
- Select update, registered, one cycle after the pulse:
  - press[0] only: btn_sel = btn_sel+1 mod 4 (11 -> 00 wraps).
  - press[1] only: btn_sel = btn_sel-1 mod 4 (00 -> 11 wraps).
  - Both in the same cycle: no change.
  - Held button: exactly one step per accepted press; no auto-repeat.
- Glitch shorter than DB_CYCLES: no change in btn_level, btn_press or btn_sel.
- Reset asserted mid-WAIT or mid-pulse: immediate return to LOW/00. A pending press is discarded.
- Button held through reset release: the FSM starts in LOW and yields a normal press after DB_CYCLES.

Decomposition:
- Shared package: FSM state encoding (LOW=2'b00, WAIT_HIGH=2'b01, HIGH=2'b10, WAIT_LOW=2'b11) and select codes (SEL_A=2'b00, SEL_B=2'b01, SEL_SUM=2'b10, SEL_SUM2=2'b11).
- One sub-module, btn_debounce_1, containing the synchroniser, counter and FSM for a single button, with outputs level and press.
- Top instantiates btn_debounce_1 twice and adds the select register.

Test Plan (DB_CYCLES=4, CNT_W=3, SYNC_STAGES=2 in simulation):
1. Reset held 5 cycles, then released with btn_raw=00 -> btn_sel=00, btn_level=00, btn_press=00 for 20 cycles.
2. btn_raw[0] driven 1 for 20 cycles -> one btn_press[0] pulse within the specified latency window; btn_level[0]=1; btn_sel goes 00 -> 01 one cycle later. A further 3 clean presses step btn_sel 10, 11, 00 (wrap).
3. From btn_sel=00, a clean btn_raw[1] press -> btn_sel=11 (wrap down). No pulse on release; btn_level[1] falls 4+2+1 cycles after release.
4. btn_raw[0] toggled 1 for 2 cycles, 0 for 1, 1 for 2, then 0 -> no pulse; btn_level and btn_sel unchanged.
5. Both buttons pressed with identical timing -> both btn_press bits pulse in the same cycle; btn_sel unchanged.
6. Reset asserted 2 cycles into WAIT_HIGH, with btn_sel=10 beforehand -> outputs immediately 0. After release with the button still held -> exactly one pulse after the debounce interval; btn_sel=01.
